// File: rtl/sram_b_fifo_ctrl.sv
// rtl/sram_b_fifo_ctrl.sv - FIFO controller around a 1w:1r sram_b with a 2-entry registered output buffer
//
// Purpose: streams words through an external 1-write/1-read SRAM. Reads are
// issued ahead into a 2-entry output buffer so that one push and one pop per
// cycle are sustained despite the one-cycle SRAM read latency.
//
// Ports:
//   CLK, RSTN        clock, synchronous active-low reset
//   FLUSH            synchronous discard of all contents
//   WR_VALID/WR_READY/WR_DATA   push handshake and data
//   RD_VALID/RD_READY/RD_DATA   pop handshake and registered head word
//   COUNT, FULL, EMPTY          total occupancy (memory + in-flight + buffer)
//   MEM_CE0/A0/D0/WE0/WEM0      SRAM write port
//   MEM_CE1/A1, MEM_Q1          SRAM read port, Q1 valid the cycle after CE1

module sram_b_fifo_ctrl #(
  parameter int ABITS = 16,
  parameter int DBITS = 8
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             FLUSH,
  input  logic             WR_VALID,
  output logic             WR_READY,
  input  logic [DBITS-1:0] WR_DATA,
  output logic             RD_VALID,
  input  logic             RD_READY,
  output logic [DBITS-1:0] RD_DATA,
  output logic [ABITS:0]   COUNT,
  output logic             FULL,
  output logic             EMPTY,
  output logic             MEM_CE0,
  output logic [ABITS-1:0] MEM_A0,
  output logic [DBITS-1:0] MEM_D0,
  output logic             MEM_WE0,
  output logic [DBITS-1:0] MEM_WEM0,
  output logic             MEM_CE1,
  output logic [ABITS-1:0] MEM_A1,
  input  logic [DBITS-1:0] MEM_Q1
);

  localparam logic [ABITS:0] DEPTH = {1'b1, {ABITS{1'b0}}};

  logic [ABITS-1:0] wr_ptr;
  logic [ABITS-1:0] rd_ptr;
  logic [ABITS:0]   mem_cnt;
  logic             inflight;
  logic [1:0]       ob_cnt;
  logic [DBITS-1:0] ob0;      // head of the output buffer, drives RD_DATA
  logic [DBITS-1:0] ob1;

  logic       run;
  logic       push;
  logic       pop;
  logic       rd_issue;
  logic [2:0] pipe_occ;

  // Nothing moves during reset or flush.
  assign run = RSTN & ~FLUSH;

  assign COUNT    = mem_cnt + {{ABITS{1'b0}}, inflight} + {{(ABITS-1){1'b0}}, ob_cnt};
  assign FULL     = (COUNT == DEPTH);
  assign EMPTY    = (COUNT == '0);
  assign WR_READY = RSTN & ~FULL;
  assign RD_VALID = (ob_cnt != 2'd0);
  assign RD_DATA  = ob0;

  assign push = run & WR_VALID & WR_READY;
  assign pop  = run & RD_READY & RD_VALID;

  // Words already committed to the buffer (held or arriving next edge).
  // A read may be issued only if its result will find a free buffer slot,
  // counting the slot freed by a pop in this cycle.
  assign pipe_occ = {1'b0, ob_cnt} + {2'b00, inflight};
  assign rd_issue = run & (mem_cnt != '0) & ((pipe_occ - {2'b00, pop}) < 3'd2);

  // A word written this cycle is only counted in mem_cnt from the next
  // cycle, so the read port can never address the word being written.
  assign MEM_CE0  = push;
  assign MEM_WE0  = push;
  assign MEM_WEM0 = {DBITS{push}};
  assign MEM_A0   = wr_ptr;
  assign MEM_D0   = WR_DATA;
  assign MEM_CE1  = rd_issue;
  assign MEM_A1   = rd_ptr;

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      mem_cnt  <= '0;
      inflight <= 1'b0;
      ob_cnt   <= 2'd0;
      ob0      <= '0;
      ob1      <= '0;
    end else if (FLUSH) begin
      // Dropping inflight discards the MEM_Q1 that arrives next cycle.
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      mem_cnt  <= '0;
      inflight <= 1'b0;
      ob_cnt   <= 2'd0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_issue) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      mem_cnt  <= mem_cnt + {{ABITS{1'b0}}, push} - {{ABITS{1'b0}}, rd_issue};
      inflight <= rd_issue;

      // A capture always finds ob_cnt <= 1 thanks to the issue rule above.
      case ({pop, inflight})
        2'b10: begin
          ob0    <= ob1;
          ob_cnt <= ob_cnt - 2'd1;
        end
        2'b01: begin
          if (ob_cnt == 2'd0) begin
            ob0 <= MEM_Q1;
          end else begin
            ob1 <= MEM_Q1;
          end
          ob_cnt <= ob_cnt + 2'd1;
        end
        2'b11: begin
          if (ob_cnt == 2'd1) begin
            ob0 <= MEM_Q1;
          end else begin
            ob0 <= ob1;
            ob1 <= MEM_Q1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_b_fifo_ctrl.sv
// tb/tb_sram_b_fifo_ctrl.sv - randomized scoreboard bench for sram_b_fifo_ctrl

module tb_sram_b_fifo_ctrl;

  localparam int ABITS = 4;
  localparam int DBITS = 8;
  localparam int DEPTH = 1 << ABITS;

  logic             clk;
  logic             rstn;
  logic             flush;
  logic             wr_valid;
  logic             wr_ready;
  logic [DBITS-1:0] wr_data;
  logic             rd_valid;
  logic             rd_ready;
  logic [DBITS-1:0] rd_data;
  logic [ABITS:0]   count;
  logic             full;
  logic             empty;
  logic             mem_ce0;
  logic [ABITS-1:0] mem_a0;
  logic [DBITS-1:0] mem_d0;
  logic             mem_we0;
  logic [DBITS-1:0] mem_wem0;
  logic             mem_ce1;
  logic [ABITS-1:0] mem_a1;
  logic [DBITS-1:0] mem_q1;

  sram_b_fifo_ctrl #(.ABITS(ABITS), .DBITS(DBITS)) dut (
    .CLK(clk), .RSTN(rstn), .FLUSH(flush),
    .WR_VALID(wr_valid), .WR_READY(wr_ready), .WR_DATA(wr_data),
    .RD_VALID(rd_valid), .RD_READY(rd_ready), .RD_DATA(rd_data),
    .COUNT(count), .FULL(full), .EMPTY(empty),
    .MEM_CE0(mem_ce0), .MEM_A0(mem_a0), .MEM_D0(mem_d0),
    .MEM_WE0(mem_we0), .MEM_WEM0(mem_wem0),
    .MEM_CE1(mem_ce1), .MEM_A1(mem_a1), .MEM_Q1(mem_q1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural 1w:1r SRAM with one-cycle read latency.
  logic [DBITS-1:0] sram [0:DEPTH-1];
  always @(posedge clk) begin
    if (mem_ce0 && mem_we0) begin
      sram[mem_a0] <= (sram[mem_a0] & ~mem_wem0) | (mem_d0 & mem_wem0);
    end
    if (mem_ce1) begin
      mem_q1 <= sram[mem_a1];
    end
  end

  // Reference model: queue of words with the cycle each was pushed.
  // The head word becomes poppable three cycles after its push.
  logic [DBITS-1:0] q_data [$];
  int               q_stamp [$];
  int               cyc;
  int               wr_idx;
  int               rd_idx;
  int               n_tests;
  int               n_fail;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic tick();
    logic exp_push;
    logic exp_pop;
    logic exp_rv;
    logic saw_ce1;
    int   n;
    exp_push = 1'b0;
    exp_pop  = 1'b0;
    @(negedge clk);
    n       = q_data.size();
    exp_rv  = (n > 0) && (q_stamp[0] + 3 <= cyc);
    saw_ce1 = mem_ce1;
    if (!rstn) begin
      check_eq("rst_wr_ready", wr_ready, 0);
      check_eq("rst_ce0", mem_ce0, 0);
      check_eq("rst_we0", mem_we0, 0);
      check_eq("rst_ce1", mem_ce1, 0);
    end else begin
      check_eq("count", count, n);
      check_eq("empty", empty, n == 0);
      check_eq("full", full, n == DEPTH);
      check_eq("wr_ready", wr_ready, n < DEPTH);
      check_eq("rd_valid", rd_valid, exp_rv);
      exp_push = !flush && wr_valid && (n < DEPTH);
      exp_pop  = !flush && rd_ready && exp_rv;
      check_eq("ce0", mem_ce0, exp_push);
      check_eq("we0", mem_we0, exp_push);
      check_eq("wem0", mem_wem0, exp_push ? 8'hff : 8'h00);
      if (exp_push) begin
        check_eq("a0", mem_a0, wr_idx % DEPTH);
        check_eq("d0", mem_d0, wr_data);
      end
      if (flush) begin
        check_eq("flush_ce1", mem_ce1, 0);
      end
      if (mem_ce1) begin
        check_eq("a1", mem_a1, rd_idx % DEPTH);
        check_eq("same_addr", mem_ce0 && mem_we0 && (mem_a0 == mem_a1), 0);
      end
      if (exp_pop) begin
        check_eq("rd_data", rd_data, q_data[0]);
      end
    end
    @(posedge clk);
    if (!rstn || flush) begin
      q_data.delete();
      q_stamp.delete();
      wr_idx = 0;
      rd_idx = 0;
    end else begin
      if (exp_pop) begin
        void'(q_data.pop_front());
        void'(q_stamp.pop_front());
      end
      if (exp_push) begin
        q_data.push_back(wr_data);
        q_stamp.push_back(cyc);
        wr_idx++;
      end
      if (saw_ce1) begin
        rd_idx++;
      end
    end
    cyc++;
    #1;
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    cyc      = 0;
    wr_idx   = 0;
    rd_idx   = 0;
    rstn     = 1'b0;
    flush    = 1'b0;
    wr_valid = 1'b0;
    wr_data  = '0;
    rd_ready = 1'b0;
    #1;
    repeat (2) tick();
    rstn = 1'b1;
    check_eq("rst_rd_data", rd_data, 0);
    repeat (2) tick();

    // Single word with immediate pop.
    rd_ready = 1'b1;
    wr_valid = 1'b1;
    wr_data  = 8'hA5;
    tick();
    wr_valid = 1'b0;
    repeat (5) tick();

    // Back-to-back streaming across many pointer wraps.
    for (int i = 0; i < 256; i++) begin
      wr_valid = 1'b1;
      wr_data  = 8'(i);
      tick();
    end
    wr_valid = 1'b0;
    repeat (6) tick();

    // Fill to FULL with no pops; the 17th push is refused.
    rd_ready = 1'b0;
    for (int i = 0; i <= DEPTH; i++) begin
      wr_valid = 1'b1;
      wr_data  = 8'(i);
      tick();
    end
    wr_valid = 1'b0;
    repeat (2) tick();
    rd_ready = 1'b1;
    repeat (DEPTH + 4) tick();

    // Flush in the middle of a stream while a read is in flight.
    for (int i = 0; i < 6; i++) begin
      wr_valid = 1'b1;
      wr_data  = 8'(8'h80 + i);
      tick();
    end
    flush = 1'b1;
    tick();
    flush    = 1'b0;
    wr_valid = 1'b0;
    tick();
    wr_valid = 1'b1;
    wr_data  = 8'h3C;
    tick();
    wr_valid = 1'b0;
    repeat (5) tick();

    // Random traffic with stalls and occasional flushes.
    for (int i = 0; i < 400; i++) begin
      wr_valid = ($urandom_range(0, 3) != 0);
      wr_data  = 8'($urandom);
      rd_ready = (i < 200) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 3) == 0);
      flush    = ($urandom_range(0, 63) == 0);
      tick();
    end
    flush = 1'b0;

    // One-cycle reset in the middle of a stream.
    rd_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wr_valid = 1'b1;
      wr_data  = 8'($urandom);
      rstn     = (i != 5);
      tick();
    end
    rstn = 1'b1;

    // Random traffic again, then drain.
    for (int i = 0; i < 200; i++) begin
      wr_valid = ($urandom_range(0, 1) != 0);
      wr_data  = 8'($urandom);
      rd_ready = ($urandom_range(0, 1) != 0);
      tick();
    end
    wr_valid = 1'b0;
    rd_ready = 1'b1;
    repeat (DEPTH + 6) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_b_fifo_ctrl.md
SRAM_B_FIFO_CTRL -- requirements
Module: sram_b_fifo_ctrl

Interface
REQ-001 SHALL have parameter ABITS, default 16, meaning memory address width; depth = 2^ABITS words.
REQ-002 SHALL have parameter DBITS, default 8, meaning word width.
REQ-003 SHALL have port CLK  in  1  sole clock; all state updates on posedge CLK.
REQ-004 SHALL have port RSTN  in  1  reset, synchronous and active-low.
REQ-005 SHALL have port FLUSH  in  1  synchronous discard of all contents.
REQ-006 SHALL have port WR_VALID  in  1  push request.
REQ-007 SHALL have port WR_READY  out  1  push accepted when WR_VALID & WR_READY.
REQ-008 SHALL have port WR_DATA  in  DBITS  push data.
REQ-009 SHALL have port RD_VALID  out  1  head word available.
REQ-010 SHALL have port RD_READY  in  1  pop when RD_VALID & RD_READY.
REQ-011 SHALL have port RD_DATA  out  DBITS  head word, registered.
REQ-012 SHALL have port COUNT  out  ABITS+1  total occupancy.
REQ-013 SHALL have port FULL  out  1  COUNT == 2^ABITS.
REQ-014 SHALL have port EMPTY  out  1  COUNT == 0.
REQ-015 SHALL have ports MEM_CE0/MEM_A0/MEM_D0/MEM_WE0/MEM_WEM0  out  1/ABITS/DBITS/1/DBITS  write port of a 1w:1r sram_b instance.
REQ-016 SHALL have ports MEM_CE1/MEM_A1  out  1/ABITS, and MEM_Q1  in  DBITS, forming the read port; Q1 is valid the cycle after CE1.

Function
REQ-017 SHALL keep wr_ptr, rd_ptr (ABITS, wrap 2^ABITS-1 -> 0), mem_cnt (ABITS+1), inflight flag, and a 2-entry output buffer (ob_cnt 0..2).
REQ-018 SHALL compute COUNT = mem_cnt + inflight + ob_cnt; WR_READY = !FULL while RSTN high.
REQ-019 SHALL, on push, drive MEM_CE0=1, MEM_WE0=1, MEM_WEM0=all ones, MEM_A0=wr_ptr, MEM_D0=WR_DATA combinationally in the same cycle; increment wr_ptr and mem_cnt.
REQ-020 SHALL drive MEM_CE0=MEM_WE0=0 and MEM_WEM0=0 when no push.
REQ-021 SHALL issue a read (MEM_CE1=1, MEM_A1=rd_ptr) when mem_cnt>0 and ob_cnt + inflight - pop < 2; increment rd_ptr, decrement mem_cnt, set inflight for next cycle.
REQ-022 SHALL drive MEM_A1=rd_ptr, MEM_CE1=0 when no read is issued.
REQ-023 SHALL capture MEM_Q1 into the output buffer at the edge ending a cycle with inflight=1.
REQ-024 SHALL present the oldest buffered word on RD_DATA; RD_VALID = (ob_cnt>0).
REQ-025 SHALL order data strictly FIFO across memory, in-flight and buffer stages.
REQ-026 SHALL make a word pushed in cycle t readable from memory no earlier than t+1: push at t -> read t+1 -> capture at end of t+2 -> RD_VALID high at t+3.
REQ-027 SHALL sustain one push and one pop per cycle in steady state.
REQ-028 SHALL handle simultaneous push and pop with COUNT unchanged.
REQ-029 SHALL never assert MEM_WE0 and MEM_CE1 to the same address in one cycle (wr_ptr==rd_ptr only when mem_cnt is 0 or FULL).
REQ-030 SHALL treat a push while FULL as no push; state unchanged.
REQ-031 SHALL treat a pop while !RD_VALID as no pop.
REQ-032 SHALL, on FLUSH=1 (RSTN high), clear pointers, mem_cnt, inflight and ob_cnt at that edge; MEM_Q1 in the following cycle is discarded; pushes and pops in the FLUSH cycle are ignored and MEM_CE0/MEM_CE1 are held 0.

Reset
REQ-033 SHALL, when RSTN=0 at a posedge, clear wr_ptr, rd_ptr, mem_cnt, inflight, ob_cnt and RD_DATA to 0.
REQ-034 SHALL hold WR_READY=0 and all MEM_CE*/MEM_WE0 at 0 while RSTN=0.
REQ-035 SHALL, after reset, present RD_VALID=0, COUNT=0, EMPTY=1, FULL=0, WR_READY=1.
REQ-036 SHALL, on reset mid-operation, discard all content and any in-flight read.

Verification
REQ-037 Single word: push 0xA5 at cycle 0, RD_READY=1 -> MEM_CE1=1 with A1=0 at cycle 1; RD_VALID=1 with RD_DATA=0xA5 at cycle 3; EMPTY at cycle 4.
REQ-038 Streaming: push 0..255 back-to-back with RD_READY=1 -> pops in order at one per cycle after 3-cycle latency; no write/read same-address cycle.
REQ-039 Fill (ABITS=4): 16 pushes, RD_READY=0 -> FULL=1, WR_READY=0, COUNT=16; 17th push ignored; one pop -> WR_READY=1 next cycle; drain returns 0..15 in order.
REQ-040 Wrap-around (ABITS=4): 40 pushes/pops with random RD_READY stalls -> correct order across pointer wrap, COUNT matches scoreboard.
REQ-041 FLUSH with a read in flight -> next cycle COUNT=0, RD_VALID=0; the following push 0x3C reads back 0x3C, not stale data.
REQ-042 RSTN=0 for one cycle mid-stream -> outputs match REQ-035 next cycle; MEM_CE0=MEM_CE1=0 during reset.
